// File: rtl/symbol_feeder.sv
// symbol_feeder: turns a byte stream into bit-pair symbols for a downstream
// pulse-shaping filter. Each byte is sent MSB first as four (bit1, bit2)
// pairs, each pair held for SPS clock cycles while gate is high. A one-entry
// hold register lets the next byte queue up so consecutive bytes stream
// without a gap. When a byte finishes and nothing is waiting, underrun pulses
// once and the filter inputs freeze.
module symbol_feeder #(
    parameter int SPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       bit1,
    output logic       bit2,
    output logic       gate,
    output logic       busy,
    output logic       underrun
);

    localparam int              SMP_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Registered state
    logic [0:0]       state;
    logic [7:0]       hold_data;
    logic             hold_full;
    logic [7:0]       shift_data;
    logic [1:0]       sym_cnt;
    logic [SMP_W-1:0] smp_cnt;

    // Next-state values
    logic [0:0]       state_nxt;
    logic [7:0]       hold_data_nxt;
    logic             hold_full_nxt;
    logic [7:0]       shift_nxt;
    logic [1:0]       sym_nxt;
    logic [SMP_W-1:0] smp_nxt;
    logic             bit1_nxt;
    logic             bit2_nxt;
    logic             underrun_nxt;

    logic             accept;
    logic             byte_end;
    logic             transfer;

    // Next-state logic: sample/symbol counting, hold-to-shifter transfer, byte acceptance
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        state_nxt     = state;
        hold_data_nxt = hold_data;
        hold_full_nxt = hold_full;
        shift_nxt     = shift_data;
        sym_nxt       = sym_cnt;
        smp_nxt       = smp_cnt;
        underrun_nxt  = 1'b0;

        accept   = in_valid && in_ready;
        byte_end = (state == S_RUN) && (smp_cnt == SMP_LAST) && (sym_cnt == 2'd3);
        transfer = hold_full && ((state == S_IDLE) || byte_end);

        if (state == S_RUN) begin
            if (smp_cnt == SMP_LAST) begin
                smp_nxt   = '0;
                shift_nxt = {shift_data[5:0], 2'b00};
                sym_nxt   = sym_cnt + 2'd1;
            end else begin
                smp_nxt = smp_cnt + 1'b1;
            end
            if (byte_end && !hold_full) begin
                state_nxt    = S_IDLE;
                underrun_nxt = 1'b1;
            end
        end

        // A waiting byte takes over the shifter and restarts the counters.
        if (transfer) begin
            shift_nxt     = hold_data;
            hold_full_nxt = 1'b0;
            sym_nxt       = 2'd0;
            smp_nxt       = '0;
            state_nxt     = S_RUN;
        end

        // in_ready is low whenever hold_full is set, so this never collides with a transfer.
        if (accept) begin
            hold_data_nxt = in_data;
            hold_full_nxt = 1'b1;
        end

        // Filter inputs follow the shifter only while running; in IDLE they freeze.
        if (state_nxt == S_RUN) begin
            bit1_nxt = shift_nxt[7];
            bit2_nxt = shift_nxt[6];
        end else begin
            bit1_nxt = bit1;
            bit2_nxt = bit2;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shift_data <= '0;
            sym_cnt    <= 2'd0;
            smp_cnt    <= '0;
            in_ready   <= 1'b1;
            bit1       <= 1'b0;
            bit2       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            hold_data  <= hold_data_nxt;
            hold_full  <= hold_full_nxt;
            shift_data <= shift_nxt;
            sym_cnt    <= sym_nxt;
            smp_cnt    <= smp_nxt;
            in_ready   <= !hold_full_nxt;
            bit1       <= bit1_nxt;
            bit2       <= bit2_nxt;
            underrun   <= underrun_nxt;
        end
    end

    // Status outputs decoded from registered state only
    always_comb begin
        gate = (state == S_RUN);
        busy = hold_full || (state == S_RUN);
    end

endmodule

// File: tb/tb_symbol_feeder.sv
// Bench for symbol_feeder: three instances (SPS = 8, 2, 16) run independent
// stimulus. Each accepted byte is expanded by a reference model into its
// 4*SPS expected (bit1, bit2) samples and queued; a monitor pops one sample
// for every gate-high cycle and also checks in_ready, busy, underrun, gate
// continuity, start latency and frozen outputs while idle.
module tb_symbol_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int SPS_G   = (g == 0) ? 8 : ((g == 1) ? 2 : 16);
        localparam int BL      = 4 * SPS_G;
        localparam int RST_POS = (BL > 16) ? 13 : (BL / 2 + 1);

        logic       rst;
        logic [7:0] in_data;
        logic       in_valid;
        logic       in_ready;
        logic       bit1;
        logic       bit2;
        logic       gate;
        logic       busy;
        logic       underrun;
        logic       lane_done = 1'b0;

        logic [1:0] exp_q[$];
        int         mon_pos = 0;

        symbol_feeder #(.SPS(SPS_G)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .bit1     (bit1),
            .bit2     (bit2),
            .gate     (gate),
            .busy     (busy),
            .underrun (underrun)
        );

        function automatic string tag(input string s);
            return $sformatf("sps%0d_%s", SPS_G, s);
        endfunction

        // Reference model: a byte becomes four MSB-first pairs, each repeated SPS times.
        task automatic push_byte(input logic [7:0] b);
            logic [1:0] pr;
            for (int p = 0; p < 4; p++) begin
                pr = b[7 - 2 * p -: 2];
                repeat (SPS_G) exp_q.push_back(pr);
            end
        endtask

        // Offer a byte, keeping in_valid high until an edge takes it.
        task automatic send(input logic [7:0] b);
            int waited = 0;
            in_valid = 1'b1;
            in_data  = b;
            while (!in_ready && waited < 4 * BL + 8) begin
                @(negedge clk); #1;
                waited++;
            end
            check(tag("accept_wait"), in_ready, 1'b1);
            if (in_ready) begin
                push_byte(b);
                @(negedge clk); #1;
            end
        endtask

        task automatic drain();
            int n = 0;
            while ((exp_q.size() != 0 || gate || busy) && n < 8 * BL + 20) begin
                @(negedge clk); #1;
                n++;
            end
            check(tag("drain"), 32'(exp_q.size()), 32'd0);
            repeat (2) begin
                @(negedge clk); #1;
            end
        endtask

        task automatic check_reset_outputs(input string when_s);
            check(tag({when_s, "_in_ready"}), in_ready, 1'b1);
            check(tag({when_s, "_bit1"}),     bit1,     1'b0);
            check(tag({when_s, "_bit2"}),     bit2,     1'b0);
            check(tag({when_s, "_gate"}),     gate,     1'b0);
            check(tag({when_s, "_busy"}),     busy,     1'b0);
            check(tag({when_s, "_underrun"}), underrun, 1'b0);
        endtask

        // Monitor: one expected sample per gate-high cycle plus handshake/status checks
        initial begin : monitor
            logic       exp_underrun;
            logic       expect_cont;
            int         idle_cnt;
            logic [1:0] last_pair;
            logic [1:0] e;
            int         sz;
            int         waiting;
            exp_underrun = 1'b0;
            expect_cont  = 1'b0;
            idle_cnt     = 0;
            last_pair    = 2'b00;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    exp_underrun = 1'b0;
                    expect_cont  = 1'b0;
                    idle_cnt     = 0;
                    last_pair    = 2'b00;
                    mon_pos      = 0;
                end else begin
                    sz = exp_q.size();
                    check(tag("underrun"), underrun, exp_underrun);
                    check(tag("busy"), busy, sz > 0);
                    if (expect_cont) check(tag("gate_continuous"), gate, 1'b1);
                    if (exp_underrun) check(tag("gate_after_end"), gate, 1'b0);
                    if (gate) begin
                        idle_cnt = 0;
                        waiting  = (sz > 0) ? (sz - 1) / BL : 0;
                        check(tag("in_ready_run"), in_ready, waiting == 0);
                        if (sz == 0) begin
                            check(tag("extra_gate"), gate, 1'b0);
                            expect_cont  = 1'b0;
                            exp_underrun = 1'b0;
                        end else begin
                            e = exp_q.pop_front();
                            check(tag("pair"), {bit1, bit2}, e);
                            last_pair    = e;
                            mon_pos      = BL - (exp_q.size() % BL);
                            exp_underrun = (exp_q.size() == 0);
                            expect_cont  = !exp_underrun;
                        end
                    end else begin
                        waiting = sz / BL;
                        check(tag("in_ready_idle"), in_ready, waiting == 0);
                        check(tag("held_pair"), {bit1, bit2}, last_pair);
                        if (sz > 0) idle_cnt++;
                        else        idle_cnt = 0;
                        check(tag("start_latency"), idle_cnt <= 1, 1'b1);
                        expect_cont  = 1'b0;
                        exp_underrun = 1'b0;
                        mon_pos      = 0;
                    end
                end
            end
        end

        // Stimulus: directed scenarios, random stream, then mid-byte and back-to-back resets
        initial begin : stim
            int n;
            int gap;
            rst      = 1'b0;
            in_valid = 1'b0;
            in_data  = '0;
            repeat (2) @(negedge clk);
            #1;
            check_reset_outputs("por");
            rst = 1'b1;

            // Single byte
            send(8'hB4);
            in_valid = 1'b0;
            drain();

            // Second byte offered while the first is running
            send(8'hFF);
            in_valid = 1'b0;
            repeat (3) begin
                @(negedge clk); #1;
            end
            send(8'h00);
            in_valid = 1'b0;
            drain();

            // Backpressure: in_valid stays high across three bytes
            send(8'hA5);
            send(8'h3C);
            send(8'hC3);
            in_valid = 1'b0;
            drain();

            // Random stream with random idle gaps (garbage data while invalid)
            for (int i = 0; i < 20; i++) begin
                gap      = $urandom_range(0, BL + 4);
                in_valid = 1'b0;
                repeat (gap) begin
                    in_data = 8'($urandom);
                    @(negedge clk); #1;
                end
                send(8'($urandom));
            end
            in_valid = 1'b0;
            drain();

            // Reset in the middle of a byte with a second byte held
            send(8'h6D);
            send(8'h92);
            in_valid = 1'b0;
            n = 0;
            while (!(gate && mon_pos == RST_POS) && n < 2 * BL + 8) begin
                @(negedge clk); #1;
                n++;
            end
            check(tag("reach_reset_point"), mon_pos, RST_POS);
            rst = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            exp_q.delete();
            repeat (3) begin
                @(negedge clk); #1;
            end
            rst = 1'b1;
            repeat (BL + 4) begin
                in_data = 8'($urandom);
                @(negedge clk); #1;
            end

            // First edge after reset release accepts a byte
            rst = 1'b0;
            #1;
            check_reset_outputs("second_reset");
            @(negedge clk); #1;
            rst = 1'b1;
            send(8'h1E);
            in_valid = 1'b0;
            drain();

            lane_done = 1'b1;
        end
    end

    // Wait for all lanes, bounded, then report
    initial begin : top_ctrl
        int n;
        n = 0;
        while (!(lane[0].lane_done && lane[1].lane_done && lane[2].lane_done) && n < 40000) begin
            @(posedge clk);
            n++;
        end
        check("all_lanes_done", {29'd0, lane[2].lane_done, lane[1].lane_done, lane[0].lane_done}, 32'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
